// File: rtl/serial_adder_if.sv
// serial_adder_if -- request/result bundle of the serial adder.
//   master: drives start, a, b, carry_in; observes busy, done, sum, carry_out, overflow
//   slave : the adder itself
//   WIDTH : operand and sum width in bits
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder -- adds two WIDTH-bit operands DIGIT bits per clock.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : serial_adder_if.slave
//         start/a/b/carry_in are sampled only on the accepting edge (IDLE or DONE);
//         busy is high during RUN, done pulses for the single DONE cycle;
//         sum/carry_out/overflow are registered and hold until the next DONE.
// Flow: IDLE --start--> RUN (WIDTH/DIGIT cycles) --> DONE (1 cycle) --> IDLE,
//       with start in DONE going straight back to RUN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] psum_r;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic             carry_out_r;
    logic             overflow_r;

    logic [DIGIT:0]   digit_sum_s;
    logic [WIDTH-1:0] digit_ext_s;
    logic [WIDTH-1:0] psum_next_s;
    logic             last_s;
    logic             ovf_s;

    // Digit adder, partial-sum shift and overflow of the current (possibly final) digit
    always_comb begin
        digit_sum_s = {1'b0, a_sh_r[DIGIT-1:0]} + {1'b0, b_sh_r[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_r};
        digit_ext_s = WIDTH'(digit_sum_s[DIGIT-1:0]);
        // New digit enters at the top; after N steps the LSB digit has reached bit 0.
        psum_next_s = (psum_r >> DIGIT) | (digit_ext_s << (WIDTH - DIGIT));
        last_s      = (cnt_r == CNT_W'(N - 1));
        // Only meaningful on the last digit, whose bit DIGIT-1 is the operand MSB.
        // Same-sign operands giving a different-sign result is exactly
        // carry-into-MSB XOR carry-out-of-MSB, and needs no intra-digit carry.
        ovf_s       = (a_sh_r[DIGIT-1] == b_sh_r[DIGIT-1]) &&
                      (digit_sum_s[DIGIT-1] != a_sh_r[DIGIT-1]);
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            psum_r      <= '0;
            sum_r       <= '0;
            cnt_r       <= '0;
            carry_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh_r  <= bus.a;
                        b_sh_r  <= bus.b;
                        carry_r <= bus.carry_in;
                        psum_r  <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= S_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh_r  <= a_sh_r >> DIGIT;
                    b_sh_r  <= b_sh_r >> DIGIT;
                    psum_r  <= psum_next_s;
                    carry_r <= digit_sum_s[DIGIT];
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        sum_r       <= psum_next_s;
                        carry_out_r <= digit_sum_s[DIGIT];
                        overflow_r  <= ovf_s;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        state_r     <= S_RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder -- scoreboard bench for serial_adder in three configurations:
//   dut8 (WIDTH=8, DIGIT=1), dut2 (WIDTH=2, DIGIT=1), dut16 (WIDTH=16, DIGIT=4).
// Expected results are pushed when start is driven and popped when done appears.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  if8 ();
    serial_adder_if #(.WIDTH(2))  if2 ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst(rst), .bus(if8));
    serial_adder #(.WIDTH(2),  .DIGIT(1)) dut2  (.clk(clk), .rst(rst), .bus(if2));
    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    typedef struct packed {
        logic [15:0] sum;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    exp_t q16[$];

    int errors = 0;
    int checks = 0;
    int done8_cnt = 0;

    // Count done pulses of the 8-bit instance, sampled at the edge
    always @(posedge clk) if (if8.done === 1'b1) done8_cnt++;

    // Reference: a+b+ci on w bits, signed overflow from operand/result signs
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input int w);
        logic [16:0] full;
        exp_t e;
        full  = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        e.co  = full[w];
        e.sum = full[15:0] & ((16'd1 << w) - 16'd1);
        e.ov  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
        return e;
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input string name);
        exp_t e;
        int lat;
        logic [7:0] hold_sum;
        logic stable;
        @(negedge clk);
        hold_sum = if8.sum;
        stable = 1'b1;
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.carry_in = ci;
        q8.push_back(model({8'd0, a}, {8'd0, b}, ci, 8));
        @(negedge clk);
        // Scramble inputs after the accepting edge: must not leak into the result.
        if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.carry_in = 1'($urandom);
        lat = 1;
        while (if8.done !== 1'b1 && lat < 40) begin
            if (if8.sum !== hold_sum) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (if8.done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: no done after %0d cycles", name, lat);
            q8.delete();
        end else begin
            e = q8.pop_front();
            checks++;
            if (lat !== 9) begin errors++; $display("FAIL %s latency: got %0d want 9", name, lat); end
            checks++;
            if (if8.sum !== e.sum[7:0]) begin errors++; $display("FAIL %s sum: got %h want %h", name, if8.sum, e.sum[7:0]); end
            checks++;
            if (if8.carry_out !== e.co) begin errors++; $display("FAIL %s carry_out: got %b want %b", name, if8.carry_out, e.co); end
            checks++;
            if (if8.overflow !== e.ov) begin errors++; $display("FAIL %s overflow: got %b want %b", name, if8.overflow, e.ov); end
            checks++;
            if (stable !== 1'b1) begin errors++; $display("FAIL %s sum_hold_in_run: got changed want %h", name, hold_sum); end
        end
        @(negedge clk);
        checks++;
        if (if8.done !== 1'b0) begin errors++; $display("FAIL %s done_pulse_width: got %b want 0", name, if8.done); end
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic ci);
        exp_t e;
        int lat;
        @(negedge clk);
        if2.start = 1'b1; if2.a = a; if2.b = b; if2.carry_in = ci;
        q2.push_back(model({14'd0, a}, {14'd0, b}, ci, 2));
        @(negedge clk);
        if2.start = 1'b0; if2.a = ~a; if2.b = ~b; if2.carry_in = ~ci;
        lat = 1;
        while (if2.done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (if2.done !== 1'b1) begin
            errors++;
            $display("FAIL w2 done_timeout a=%0d b=%0d ci=%0d", a, b, ci);
            q2.delete();
        end else begin
            e = q2.pop_front();
            checks++;
            if ({if2.carry_out, if2.sum} !== {e.co, e.sum[1:0]})
                begin errors++; $display("FAIL w2 a=%0d b=%0d ci=%0d: got co,sum=%b%b want %b%b", a, b, ci, if2.carry_out, if2.sum, e.co, e.sum[1:0]); end
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci, input string name);
        exp_t e;
        int lat;
        @(negedge clk);
        if16.start = 1'b1; if16.a = a; if16.b = b; if16.carry_in = ci;
        q16.push_back(model(a, b, ci, 16));
        @(negedge clk);
        if16.start = 1'b0; if16.a = 16'($urandom); if16.b = 16'($urandom);
        lat = 1;
        while (if16.done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (if16.done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout", name);
            q16.delete();
        end else begin
            e = q16.pop_front();
            checks++;
            if (lat !== 5) begin errors++; $display("FAIL %s latency: got %0d want 5", name, lat); end
            checks++;
            if ({if16.carry_out, if16.overflow, if16.sum} !== {e.co, e.ov, e.sum})
                begin errors++; $display("FAIL %s result: got co=%b ov=%b sum=%h want co=%b ov=%b sum=%h", name, if16.carry_out, if16.overflow, if16.sum, e.co, e.ov, e.sum); end
        end
    endtask

    task automatic test_reset;
        // rst together with start: reset must win
        rst = 1'b1;
        if8.start = 1'b1;  if8.a = 8'hA5;   if8.b = 8'h5A;   if8.carry_in = 1'b1;
        if2.start = 1'b1;  if2.a = 2'd3;    if2.b = 2'd1;    if2.carry_in = 1'b0;
        if16.start = 1'b1; if16.a = 16'h1234; if16.b = 16'h4321; if16.carry_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", if8.busy); end
        checks++;
        if (if8.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", if8.done); end
        checks++;
        if (if8.sum !== 8'h00) begin errors++; $display("FAIL reset sum: got %h want 00", if8.sum); end
        checks++;
        if (if8.carry_out !== 1'b0) begin errors++; $display("FAIL reset carry_out: got %b want 0", if8.carry_out); end
        checks++;
        if (if8.overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", if8.overflow); end
        checks++;
        if ({if2.busy, if2.done, if2.sum, if16.busy, if16.done, if16.sum} !== 20'd0)
            begin errors++; $display("FAIL reset other_instances: got nonzero want 0"); end
        rst = 1'b0;
        if8.start = 1'b0; if2.start = 1'b0; if16.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        run8(8'hFF, 8'h01, 1'b0, "ff_plus_01");
        run8(8'h7F, 8'h01, 1'b0, "7f_plus_01");
        run8(8'h80, 8'h80, 1'b1, "80_plus_80_ci");
        for (int i = 0; i < 4; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), "random8");
    endtask

    task automatic test_exhaustive_w2;
        for (int k = 0; k < 32; k++)
            run2(k[4:3], k[2:1], k[0]);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int results;
        logic exp_done;
        results = 0;
        for (int j = 0; j <= 36; j++) begin
            @(negedge clk);
            if (j > 0) begin
                exp_done = (j % 9 == 0);
                checks++;
                if (if8.done !== exp_done) begin errors++; $display("FAIL b2b done j=%0d: got %b want %b", j, if8.done, exp_done); end
                checks++;
                if (if8.busy !== ~exp_done) begin errors++; $display("FAIL b2b busy j=%0d: got %b want %b", j, if8.busy, ~exp_done); end
                if (if8.done === 1'b1 && q8.size() > 0) begin
                    e = q8.pop_front();
                    results++;
                    checks++;
                    if ({if8.carry_out, if8.overflow, if8.sum} !== {e.co, e.ov, e.sum[7:0]})
                        begin errors++; $display("FAIL b2b result j=%0d: got co=%b ov=%b sum=%h want co=%b ov=%b sum=%h", j, if8.carry_out, if8.overflow, if8.sum, e.co, e.ov, e.sum[7:0]); end
                end
            end
            if (j < 36) begin
                if8.start = 1'b1;
                if8.a = 8'($urandom); if8.b = 8'($urandom); if8.carry_in = 1'($urandom);
                if (j % 9 == 0) q8.push_back(model({8'd0, if8.a}, {8'd0, if8.b}, if8.carry_in, 8));
            end else begin
                if8.start = 1'b0;
            end
        end
        checks++;
        if (results !== 4) begin errors++; $display("FAIL b2b result_count: got %0d want 4", results); end
        q8.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int n0;
        run8(8'h7F, 8'h01, 1'b0, "pre_abort");
        n0 = done8_cnt;
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.carry_in = 1'b0;
        @(negedge clk);                 // RUN cycle 1
        if8.start = 1'b0;
        @(negedge clk);                 // RUN cycle 2
        @(negedge clk);                 // RUN cycle 3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({if8.busy, if8.done, if8.carry_out, if8.overflow, if8.sum} !== 12'd0)
            begin errors++; $display("FAIL abort outputs: got busy=%b done=%b co=%b ov=%b sum=%h want all 0", if8.busy, if8.done, if8.carry_out, if8.overflow, if8.sum); end
        repeat (12) @(negedge clk);
        checks++;
        if (done8_cnt !== n0) begin errors++; $display("FAIL abort no_done: got %0d pulses want 0", done8_cnt - n0); end
        run8(8'h55, 8'hAA, 1'b1, "after_abort");
        checks++;
        if ({if8.carry_out, if8.overflow, if8.sum} !== {1'b1, 1'b0, 8'h00})
            begin errors++; $display("FAIL after_abort hold: got co=%b ov=%b sum=%h want co=1 ov=0 sum=00", if8.carry_out, if8.overflow, if8.sum); end
    endtask

    task automatic test_digit4;
        run16(16'h8000, 16'h8000, 1'b0, "d4_8000_8000");
        checks++;
        if ({if16.carry_out, if16.overflow, if16.sum} !== {1'b1, 1'b1, 16'h0000})
            begin errors++; $display("FAIL d4 const: got co=%b ov=%b sum=%h want co=1 ov=1 sum=0000", if16.carry_out, if16.overflow, if16.sum); end
        run16(16'h7FFF, 16'h0000, 1'b1, "d4_7fff_ci");
        for (int i = 0; i < 3; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom), "d4_random");
    endtask

    initial begin
        if8.start = 1'b0; if2.start = 1'b0; if16.start = 1'b0;
        test_reset;
        test_directed;
        test_exhaustive_w2;
        test_back_to_back;
        test_reset_mid_run;
        test_digit4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
